// File: rtl/ecall_io_unit_pkg.sv
// Shared types for the ecall I/O sequencer: FSM state encoding and the
// pending-transfer kind flag.
package ecall_io_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ARM        = 2'd1,
    ST_WAIT_PRESS = 2'd2,
    ST_DONE       = 2'd3
  } ecall_state_e;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_PRINT = 1'b1
  } ecall_kind_e;

endpackage

// File: rtl/ecall_io_unit_btn_debounce.sv
// Confirm-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a single-cycle rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    level_d     = level_q;
    cnt_d       = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values; blocking
      // here would collapse the synchronizer into a single stage.
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/ecall_io_unit.sv
// Ecall I/O sequencer: stalls the pipeline for print-int / read-int ecalls,
// latches a0 for the display and returns the switch value on a confirm press.
module ecall_io_unit
  import ecall_io_unit_pkg::*;
#(
  parameter int SW_W       = 16,
  parameter int DEB_CYC    = 1_000_000,
  parameter int SIGN_EXT   = 1,
  parameter int PRINT_WAIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            eRead,
  input  logic            eWrite,
  input  logic [31:0]     a0_in,
  input  logic            confirm_btn,
  input  logic [SW_W-1:0] switches,
  output logic            stall,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [31:0]     disp_data,
  output logic            disp_valid
);

  ecall_state_e state_q, state_d;
  ecall_kind_e  kind_q, kind_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic [31:0]  disp_data_q, disp_data_d;
  logic         disp_valid_q, disp_valid_d;
  logic         btn_level, btn_rise;
  logic signed [SW_W-1:0] sw_signed;
  logic [31:0]  sw_ext;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (confirm_btn),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  assign sw_signed = switches;
  assign sw_ext    = (SIGN_EXT != 0) ? 32'(sw_signed) : 32'(switches);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    wb_data_d    = wb_data_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    wb_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (eRead) begin
          kind_d  = KIND_READ;
          state_d = ST_ARM;
        end else if (eWrite) begin
          kind_d       = KIND_PRINT;
          disp_data_d  = a0_in;
          disp_valid_d = 1'b1;
          state_d      = (PRINT_WAIT != 0) ? ST_ARM : ST_DONE;
        end
      end
      // A button still held from an earlier press must be released first.
      ST_ARM: if (!btn_level) state_d = ST_WAIT_PRESS;
      ST_WAIT_PRESS: begin
        if (btn_rise) begin
          state_d = ST_DONE;
          if (kind_q == KIND_READ) begin
            wb_valid  = 1'b1;
            wb_data_d = sw_ext;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_READ;
      wb_data_q    <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      wb_data_q    <= wb_data_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign stall = ((state_q == ST_IDLE) && (eRead || eWrite)) ||
                 (state_q == ST_ARM) || (state_q == ST_WAIT_PRESS);

  // The result is presented in the pulse cycle itself, while rd is still stalled.
  assign wb_data    = wb_valid ? wb_data_d : wb_data_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed bench for ecall_io_unit: two instances (sign- and zero-extending)
// share all stimulus; DEB_CYC=4 keeps button sequences short.
module tb_ecall_io_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        e_read, e_write, confirm_btn;
  logic [31:0] a0_in;
  logic [15:0] switches;

  logic        stall_s, wb_valid_s, disp_valid_s;
  logic [31:0] wb_data_s, disp_data_s;
  logic        stall_z, wb_valid_z, disp_valid_z;
  logic [31:0] wb_data_z, disp_data_z;

  int n_tests = 0;
  int n_fail  = 0;

  int          vcount_s, vcount_z;
  logic [31:0] vdata_s, vdata_z;
  logic        vstall, post_stall, prev_v;

  always #5 clk = ~clk;

  ecall_io_unit #(.SW_W(16), .DEB_CYC(4), .SIGN_EXT(1), .PRINT_WAIT(0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .eRead(e_read), .eWrite(e_write), .a0_in(a0_in),
    .confirm_btn(confirm_btn), .switches(switches), .stall(stall_s),
    .wb_valid(wb_valid_s), .wb_data(wb_data_s), .disp_data(disp_data_s),
    .disp_valid(disp_valid_s)
  );

  ecall_io_unit #(.SW_W(16), .DEB_CYC(4), .SIGN_EXT(0), .PRINT_WAIT(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .eRead(e_read), .eWrite(e_write), .a0_in(a0_in),
    .confirm_btn(confirm_btn), .switches(switches), .stall(stall_z),
    .wb_valid(wb_valid_z), .wb_data(wb_data_z), .disp_data(disp_data_z),
    .disp_valid(disp_valid_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    vcount_s = 0; vcount_z = 0;
    vdata_s = '0; vdata_z = '0;
    vstall = 1'b0; post_stall = 1'b1; prev_v = 1'b0;
  endtask

  // Run n cycles, logging wb_valid pulses and the stall level around them.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (prev_v) post_stall = stall_s;
      prev_v = wb_valid_s;
      if (wb_valid_s) begin
        vcount_s++;
        vdata_s = wb_data_s;
        vstall  = stall_s;
      end
      if (wb_valid_z) begin
        vcount_z++;
        vdata_z = wb_data_z;
      end
    end
  endtask

  task automatic request_read(input string tag);
    e_read = 1'b1;
    #1;
    check({tag, "_req_stall"}, 32'(stall_s), 32'd1);
    tick();
    e_read = 1'b0;
  endtask

  task automatic press(input int hold);
    confirm_btn = 1'b1;
    watch(hold);
    confirm_btn = 1'b0;
    watch(10);
  endtask

  initial begin
    rst_n = 1'b0; e_read = 1'b0; e_write = 1'b0; confirm_btn = 1'b0;
    a0_in = '0; switches = '0;
    clr_mon();
    repeat (3) tick();
    check("rst_stall",      32'(stall_s),      32'd0);
    check("rst_wb_valid",   32'(wb_valid_s),   32'd0);
    check("rst_wb_data",    wb_data_s,         32'd0);
    check("rst_disp_data",  disp_data_s,       32'd0);
    check("rst_disp_valid", 32'(disp_valid_s), 32'd0);
    rst_n = 1'b1;
    tick();

    // Print: one stall cycle, display update pulsed in DONE.
    a0_in = 32'h0000_002A; e_write = 1'b1;
    #1;
    check("prt_req_stall", 32'(stall_s), 32'd1);
    check("prt_req_dv",    32'(disp_valid_s), 32'd0);
    tick();
    a0_in = 32'h0000_0099;
    #1;
    check("prt_done_stall", 32'(stall_s), 32'd0);
    check("prt_done_dv",    32'(disp_valid_s), 32'd1);
    check("prt_done_data",  disp_data_s, 32'h0000_002A);
    tick();
    e_write = 1'b0;
    #1;
    check("prt_ignored_dv",   32'(disp_valid_s), 32'd0);
    check("prt_ignored_data", disp_data_s, 32'h0000_002A);
    tick();

    // Read, sign- and zero-extended, button held 10 cycles.
    switches = 16'h8001;
    clr_mon();
    request_read("rd");
    press(10);
    check("rd_count_s",   32'(vcount_s), 32'd1);
    check("rd_count_z",   32'(vcount_z), 32'd1);
    check("rd_data_s",    vdata_s, 32'hFFFF_8001);
    check("rd_data_z",    vdata_z, 32'h0000_8001);
    check("rd_vstall",    32'(vstall), 32'd1);
    check("rd_done_stall", 32'(post_stall), 32'd0);
    check("rd_hold_s",    wb_data_s, 32'hFFFF_8001);

    // Held button at request: needs release plus a fresh press.
    switches = 16'h1234;
    confirm_btn = 1'b1;
    repeat (10) tick();
    clr_mon();
    request_read("hold");
    confirm_btn = 1'b1;
    watch(12);
    check("hold_no_valid", 32'(vcount_s), 32'd0);
    check("hold_stall",    32'(stall_s), 32'd1);
    confirm_btn = 1'b0;
    watch(8);
    check("hold_rel_no_valid", 32'(vcount_s), 32'd0);
    check("hold_rel_stall",    32'(stall_s), 32'd1);
    press(10);
    check("hold_count", 32'(vcount_s), 32'd1);
    check("hold_data",  vdata_s, 32'h0000_1234);

    // Glitches of two cycles must not confirm.
    switches = 16'h7FFF;
    clr_mon();
    request_read("glt");
    tick();
    for (int g = 0; g < 3; g++) begin
      confirm_btn = 1'b1;
      watch(2);
      confirm_btn = 1'b0;
      watch(3);
    end
    check("glt_no_valid", 32'(vcount_s), 32'd0);
    check("glt_stall",    32'(stall_s), 32'd1);
    press(10);
    check("glt_count_z", 32'(vcount_z), 32'd1);
    check("glt_data_s",  vdata_s, 32'h0000_7FFF);

    // eRead and eWrite together: read wins, display untouched.
    switches = 16'hFFFF;
    a0_in = 32'hDEAD_BEEF;
    e_write = 1'b1;
    clr_mon();
    request_read("both");
    e_write = 1'b0;
    #1;
    check("both_dv",    32'(disp_valid_s), 32'd0);
    check("both_stall", 32'(stall_s), 32'd1);
    press(10);
    check("both_data_s", vdata_s, 32'hFFFF_FFFF);
    check("both_data_z", vdata_z, 32'h0000_FFFF);
    check("both_disp",   disp_data_s, 32'h0000_002A);

    // Reset during WAIT_PRESS drops the transfer.
    switches = 16'h00C3;
    clr_mon();
    request_read("rst");
    tick();
    check("rst_wp_stall", 32'(stall_s), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall",   32'(stall_s), 32'd0);
    check("rst_mid_wb_data", wb_data_s, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    press(10);
    check("rst_no_valid",    32'(vcount_s + vcount_z), 32'd0);
    check("rst_end_stall",   32'(stall_s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
